// File: rtl/ram_port_a_arbiter.sv
// Round-robin arbiter/sequencer for port A of a byte-write-enable dual-port RAM.
// Two requesters, three-state IDLE/ACCESS/RESP sequence, one access per three cycles.
module ram_port_a_arbiter #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [NUM_COL-1:0]    we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [NUM_COL-1:0]    we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [NUM_COL-1:0]    ram_weA,
    output logic [ADDR_WIDTH-1:0] ram_addrA,
    output logic [DATA_WIDTH-1:0] ram_dinA,
    input  logic [DATA_WIDTH-1:0] ram_doutA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_prio;
    logic                  r_grant;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_busy;
    logic [NUM_COL-1:0]    r_weA;
    logic [ADDR_WIDTH-1:0] r_addrA;
    logic [DATA_WIDTH-1:0] r_dinA;
    logic                  w_sel;

    // Requester 1 wins if it is alone or if the pointer favours it.
    always_comb begin
        w_sel = req1 && (!req0 || r_prio);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_grant <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
            r_weA   <= '0;
            r_addrA <= '0;
            r_dinA  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_grant <= w_sel;
                        r_weA   <= w_sel ? we1   : we0;
                        r_addrA <= w_sel ? addr1 : addr0;
                        r_dinA  <= w_sel ? din1  : din0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Enables live for exactly this cycle; ack lands in RESP.
                    r_weA   <= '0;
                    r_ack0  <= !r_grant;
                    r_ack1  <= r_grant;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_prio  <= !r_grant;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign busy      = r_busy;
    assign ram_weA   = r_weA;
    assign ram_addrA = r_addrA;
    assign ram_dinA  = r_dinA;
    assign rdata     = ram_doutA;

endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// Scoreboard bench for ram_port_a_arbiter with a behavioural read-first byte-enable RAM on port A.
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_ram_port_a_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [3:0]  we0, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] din0, din1;
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic        busy;
    logic [3:0]  ram_weA;
    logic [11:0] ram_addrA;
    logic [31:0] ram_dinA;
    logic [31:0] ram_doutA;

    logic [31:0] mem [0:4095];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    ram_port_a_arbiter #(
        .NUM_COL   (4),
        .COL_WIDTH (8),
        .ADDR_WIDTH(12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .din0     (din0),
        .ack0     (ack0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .din1     (din1),
        .ack1     (ack1),
        .rdata    (rdata),
        .busy     (busy),
        .ram_weA  (ram_weA),
        .ram_addrA(ram_addrA),
        .ram_dinA (ram_dinA),
        .ram_doutA(ram_doutA)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Port A of the block RAM: registered output, read-first, byte enables.
    always @(posedge clk) begin
        ram_doutA <= mem[ram_addrA];
        for (int c = 0; c < 4; c++)
            if (ram_weA[c]) mem[ram_addrA][c*8 +: 8] <= ram_dinA[c*8 +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack0 || ack1) begin
            chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_id", {31'd0, ack1}, {31'd0, e.id});
                chk("rdata", rdata, e.data);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
        if (ram_weA != 4'd0)
            chk("weA_only_in_access", {30'd0, busy, ack0 | ack1}, 32'd2);
    end

    task automatic drive(input bit id, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
        if (id) begin
            req1 = 1'b1; we1 = we; addr1 = a; din1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; din0 = d;
        end
    endtask

    task automatic wait_ack(input bit id);
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = id ? ack1 : ack0;
        end
        chk(id ? "ack1_seen" : "ack0_seen", {31'd0, got}, 32'd1);
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic access(input bit id, input logic [3:0] we, input logic [11:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        drive(id, we, a, d);
        sb.push_back('{id: id, data: exp, cyc: cyc + 2});
        wait_ack(id);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
        chk({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_weA"}, {28'd0, ram_weA}, 32'd0);
        chk({tag, "_addrA"}, {20'd0, ram_addrA}, 32'd0);
        chk({tag, "_dinA"}, ram_dinA, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        rst = 1'b1;
        req0 = 1'b0; we0 = 4'd0; addr0 = 12'd0; din0 = 32'd0;
        req1 = 1'b0; we1 = 4'd0; addr1 = 12'd0; din1 = 32'd0;
        mem[12'h010] = 32'hDEADBEEF;
        mem[12'h020] = 32'h11223344;
        mem[12'h040] = 32'h0A0A0A0A;
        mem[12'h041] = 32'h1B1B1B1B;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read by requester 0.
        access(1'b0, 4'b0000, 12'h010, 32'h0, 32'hDEADBEEF);
        @(negedge clk);

        // Byte write by requester 1 returns the old word, then read back the merge.
        access(1'b1, 4'b0101, 12'h020, 32'hAABBCCDD, 32'h11223344);
        @(negedge clk);
        access(1'b0, 4'b0000, 12'h020, 32'h0, 32'h11BB33DD);
        chk("mem_merge", mem[12'h020], 32'h11BB33DD);
        @(negedge clk);

        // Last grant was requester 0, so requester 1 wins the simultaneous rise.
        @(negedge clk);
        drive(1'b0, 4'b0000, 12'h040, 32'h0);
        drive(1'b1, 4'b0000, 12'h041, 32'h0);
        sb.push_back('{id: 1'b1, data: 32'h1B1B1B1B, cyc: cyc + 2});
        sb.push_back('{id: 1'b0, data: 32'h0A0A0A0A, cyc: cyc + 5});
        wait_ack(1'b1);
        wait_ack(1'b0);
        repeat (2) @(negedge clk);

        // Contention from reset: strict alternation starting with requester 0.
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset2");
        drive(1'b0, 4'b0000, 12'h040, 32'h0);
        drive(1'b1, 4'b0000, 12'h041, 32'h0);
        rst = 1'b0;
        sb.push_back('{id: 1'b0, data: 32'h0A0A0A0A, cyc: cyc + 2});
        sb.push_back('{id: 1'b1, data: 32'h1B1B1B1B, cyc: cyc + 5});
        sb.push_back('{id: 1'b0, data: 32'h0A0A0A0A, cyc: cyc + 8});
        sb.push_back('{id: 1'b1, data: 32'h1B1B1B1B, cyc: cyc + 11});
        repeat (12) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("contention_drained", sb.size(), 32'd0);

        // Reset during ACCESS aborts the write.
        @(negedge clk);
        drive(1'b0, 4'b1111, 12'h030, 32'hFFFFFFFF);
        @(negedge clk);
        chk("abort_weA_live", {28'd0, ram_weA}, 32'hF);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        req0 = 1'b0; we0 = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_mem", mem[12'h030], 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // One-cycle request pulse still completes once.
        @(negedge clk);
        drive(1'b0, 4'b0000, 12'h010, 32'h0);
        sb.push_back('{id: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 2});
        @(negedge clk);
        req0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("pulse_drained", sb.size(), 32'd0);
        chk("pulse_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
